// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-record path: record layout, pending-slot states, field widths.
// Record address/data fields are REC_XLEN wide; the top-level XLEN parameter must match it.
package commit_trace_pkg;

    localparam int MEMW_W   = 6;
    localparam int INST_W   = 32;
    localparam int REC_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_R  = 2'd1,
        PEND_W  = 2'd2,
        PEND_RW = 2'd3
    } pend_state_e;

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [REC_XLEN-1:0] pc;
        logic                rd_valid;
        logic [REC_XLEN-1:0] rd_addr;
        logic [REC_XLEN-1:0] rd_data;
        logic [MEMW_W-1:0]   rd_width;
        logic                wr_valid;
        logic [REC_XLEN-1:0] wr_addr;
        logic [REC_XLEN-1:0] wr_data;
        logic [MEMW_W-1:0]   wr_width;
    } commit_rec_t;

endpackage

// File: rtl/record_fifo.sv
// Circular DEPTH-entry commit_rec_t queue. Head is registered (zero when empty), one-cycle push-to-visible.
// Push on full succeeds only alongside a pop; otherwise it is ignored and the caller flags the drop.
module record_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  commit_rec_t              push_dat,
    input  logic                     pop,
    output commit_rec_t              head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    commit_rec_t    r_mem [DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_push;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = pop && !w_empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign w_push  = push && (!w_full || w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_wptr - r_rptr;

endmodule

// File: rtl/commit_record_fifo.sv
// Fuses commits with their load/store events into records and queues them for the checker; head visible 1 cycle after commit.
// Checker back-pressure via out_ready; a commit on a full queue without a pop is dropped and sets sticky overflow.
module commit_record_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = REC_XLEN
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     instCommit_valid,
    input  logic [INST_W-1:0]        instCommit_inst,
    input  logic [XLEN-1:0]          instCommit_pc,
    input  logic                     mem_read_valid,
    input  logic [XLEN-1:0]          mem_read_addr,
    input  logic [XLEN-1:0]          mem_read_data,
    input  logic [MEMW_W-1:0]        mem_read_memWidth,
    input  logic                     mem_write_valid,
    input  logic [XLEN-1:0]          mem_write_addr,
    input  logic [XLEN-1:0]          mem_write_data,
    input  logic [MEMW_W-1:0]        mem_write_memWidth,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_rd_valid,
    output logic [XLEN-1:0]          out_rd_addr,
    output logic [XLEN-1:0]          out_rd_data,
    output logic [MEMW_W-1:0]        out_rd_width,
    output logic                     out_wr_valid,
    output logic [XLEN-1:0]          out_wr_addr,
    output logic [XLEN-1:0]          out_wr_data,
    output logic [MEMW_W-1:0]        out_wr_width,
    output logic                     overflow,
    output logic                     seq_error,
    output logic [$clog2(DEPTH):0]   count
);

    pend_state_e        r_state;
    pend_state_e        w_next;
    logic               w_pend_r;
    logic               w_pend_w;
    logic               w_has_r;
    logic               w_has_w;
    logic [XLEN-1:0]    r_rd_addr, r_rd_data, r_wr_addr, r_wr_data;
    logic [MEMW_W-1:0]  r_rd_width, r_wr_width;
    logic               r_overflow;
    logic               r_seq_error;
    commit_rec_t        w_rec;
    commit_rec_t        w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    assign w_has_r = w_pend_r || mem_read_valid;
    assign w_has_w = w_pend_w || mem_write_valid;

    always_comb begin
        w_next = r_state;
        if (instCommit_valid) begin
            w_next = IDLE;
        end else begin
            unique case ({w_has_r, w_has_w})
                2'b00:   w_next = IDLE;
                2'b10:   w_next = PEND_R;
                2'b01:   w_next = PEND_W;
                default: w_next = PEND_RW;
            endcase
        end
    end

    always_comb begin
        w_pend_r = (r_state == PEND_R) || (r_state == PEND_RW);
        w_pend_w = (r_state == PEND_W) || (r_state == PEND_RW);
    end

    // Slot payload is only meaningful while the FSM says so; a newer event simply overwrites it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_rd_width <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_width <= '0;
        end else begin
            if (mem_read_valid && !instCommit_valid) begin
                r_rd_addr  <= mem_read_addr;
                r_rd_data  <= mem_read_data;
                r_rd_width <= mem_read_memWidth;
            end
            if (mem_write_valid && !instCommit_valid) begin
                r_wr_addr  <= mem_write_addr;
                r_wr_data  <= mem_write_data;
                r_wr_width <= mem_write_memWidth;
            end
        end
    end

    always_comb begin
        w_rec          = '0;
        w_rec.inst     = instCommit_inst;
        w_rec.pc       = instCommit_pc;
        w_rec.rd_valid = w_has_r;
        w_rec.rd_addr  = mem_read_valid ? mem_read_addr     : r_rd_addr;
        w_rec.rd_data  = mem_read_valid ? mem_read_data     : r_rd_data;
        w_rec.rd_width = mem_read_valid ? mem_read_memWidth : r_rd_width;
        w_rec.wr_valid = w_has_w;
        w_rec.wr_addr  = mem_write_valid ? mem_write_addr     : r_wr_addr;
        w_rec.wr_data  = mem_write_valid ? mem_write_data     : r_wr_data;
        w_rec.wr_width = mem_write_valid ? mem_write_memWidth : r_wr_width;
    end

    assign w_pop = !w_empty && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            if (instCommit_valid && w_full && !w_pop)
                r_overflow <= 1'b1;
            if ((mem_read_valid && w_pend_r) || (mem_write_valid && w_pend_w))
                r_seq_error <= 1'b1;
        end
    end

    record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (instCommit_valid),
        .push_dat (w_rec),
        .pop      (w_pop),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (count)
    );

    assign out_valid    = !w_empty;
    assign out_inst     = w_head.inst;
    assign out_pc       = w_head.pc;
    assign out_rd_valid = w_head.rd_valid;
    assign out_rd_addr  = w_head.rd_addr;
    assign out_rd_data  = w_head.rd_data;
    assign out_rd_width = w_head.rd_width;
    assign out_wr_valid = w_head.wr_valid;
    assign out_wr_addr  = w_head.wr_addr;
    assign out_wr_data  = w_head.wr_data;
    assign out_wr_width = w_head.wr_width;
    assign overflow     = r_overflow;
    assign seq_error    = r_seq_error;

endmodule

// File: tb/tb_commit_record_fifo.sv
// Scoreboarded bench: expected records are queued as commits are driven and compared when they reach the head.
module tb_commit_record_fifo;
    import commit_trace_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instCommit_valid = 1'b0;
    logic [31:0] instCommit_inst = '0, instCommit_pc = '0;
    logic        mem_read_valid = 1'b0, mem_write_valid = 1'b0;
    logic [31:0] mem_read_addr = '0, mem_read_data = '0, mem_write_addr = '0, mem_write_data = '0;
    logic [5:0]  mem_read_memWidth = '0, mem_write_memWidth = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_rd_valid, out_wr_valid, overflow, seq_error;
    logic [31:0] out_inst, out_pc, out_rd_addr, out_rd_data, out_wr_addr, out_wr_data;
    logic [5:0]  out_rd_width, out_wr_width;
    logic [2:0]  count;

    commit_record_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset_n(reset_n),
        .instCommit_valid(instCommit_valid), .instCommit_inst(instCommit_inst), .instCommit_pc(instCommit_pc),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_read_memWidth(mem_read_memWidth),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_write_memWidth(mem_write_memWidth),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rd_valid(out_rd_valid), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .out_rd_width(out_rd_width),
        .out_wr_valid(out_wr_valid), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .out_wr_width(out_wr_width),
        .overflow(overflow), .seq_error(seq_error), .count(count)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_err = 0;
    commit_rec_t sb_q[$];
    bit          m_pr, m_pw, e_ovf, e_seq;
    logic [31:0] m_ra, m_rd, m_wa, m_wd;
    logic [5:0]  m_rw, m_ww;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_head();
        if (sb_q.size() == 0) begin
            chk("empty_valid", out_valid, 0);
            chk("empty_inst", out_inst, 0);
            chk("empty_rd_valid", out_rd_valid, 0);
            chk("empty_wr_valid", out_wr_valid, 0);
        end else begin
            chk("head_valid", out_valid, 1);
            chk("head_inst", out_inst, sb_q[0].inst);
            chk("head_pc", out_pc, sb_q[0].pc);
            chk("head_rd_valid", out_rd_valid, sb_q[0].rd_valid);
            chk("head_wr_valid", out_wr_valid, sb_q[0].wr_valid);
            if (sb_q[0].rd_valid) begin
                chk("head_rd_addr", out_rd_addr, sb_q[0].rd_addr);
                chk("head_rd_data", out_rd_data, sb_q[0].rd_data);
                chk("head_rd_width", out_rd_width, sb_q[0].rd_width);
            end
            if (sb_q[0].wr_valid) begin
                chk("head_wr_addr", out_wr_addr, sb_q[0].wr_addr);
                chk("head_wr_data", out_wr_data, sb_q[0].wr_data);
                chk("head_wr_width", out_wr_width, sb_q[0].wr_width);
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of stimulus, update the model, check after the rising edge.
    task automatic cyc(input bit c, input logic [31:0] inst, input logic [31:0] pc,
                       input bit rv, input logic [31:0] ra, input logic [31:0] rd, input logic [5:0] rw,
                       input bit wv, input logic [31:0] wa, input logic [31:0] wd, input logic [5:0] ww,
                       input bit rdy);
        commit_rec_t rec;
        bit pop_m;
        instCommit_valid = c;  instCommit_inst = inst; instCommit_pc = pc;
        mem_read_valid = rv;   mem_read_addr = ra;     mem_read_data = rd;   mem_read_memWidth = rw;
        mem_write_valid = wv;  mem_write_addr = wa;    mem_write_data = wd;  mem_write_memWidth = ww;
        out_ready = rdy;
        check_head();
        pop_m = (sb_q.size() != 0) && rdy;
        if ((rv && m_pr) || (wv && m_pw)) e_seq = 1;
        if (c) begin
            rec = '0;
            rec.inst = inst; rec.pc = pc;
            rec.rd_valid = rv || m_pr;
            rec.rd_addr  = rv ? ra : m_ra; rec.rd_data = rv ? rd : m_rd; rec.rd_width = rv ? rw : m_rw;
            rec.wr_valid = wv || m_pw;
            rec.wr_addr  = wv ? wa : m_wa; rec.wr_data = wv ? wd : m_wd; rec.wr_width = wv ? ww : m_ww;
            m_pr = 0; m_pw = 0;
        end else begin
            if (rv) begin m_pr = 1; m_ra = ra; m_rd = rd; m_rw = rw; end
            if (wv) begin m_pw = 1; m_wa = wa; m_wd = wd; m_ww = ww; end
        end
        if (pop_m) void'(sb_q.pop_front());
        if (c) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(rec);
            else                     e_ovf = 1;
        end
        @(posedge clock);
        @(negedge clock);
        chk("count", count, sb_q.size());
        chk("overflow", overflow, e_ovf);
        chk("seq_error", seq_error, e_seq);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic commit(input logic [31:0] inst, input logic [31:0] pc, input bit rdy);
        cyc(1, inst, pc, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        instCommit_valid = 0; mem_read_valid = 0; mem_write_valid = 0; out_ready = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_rd_valid", out_rd_valid, 0);
        sb_q.delete();
        m_pr = 0; m_pw = 0; e_ovf = 0; e_seq = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        @(negedge clock);
        pulse_reset();

        // Load event two cycles ahead of its commit.
        idle(1);
        cyc(0, 0, 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 6'd32, 0, 0, 0, 0, 1);
        idle(1);
        commit(32'h0002_A303, 32'h8000_0004, 1);
        idle(1);
        idle(1);

        // Store arriving with its commit.
        cyc(1, 32'h0050_0023, 32'h8000_0008, 0, 0, 0, 0, 1, 32'h100, 32'h55, 6'd8, 0);
        idle(1);
        idle(1);

        // Second load before commit: newer data wins, seq_error sticks.
        cyc(0, 0, 0, 1, 32'h200, 32'h1, 6'd32, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 32'h204, 32'h2, 6'd16, 0, 0, 0, 0, 1);
        commit(32'h0000_0003, 32'h8000_000C, 1);
        idle(1);

        // Overflow: five commits into four entries with the checker stalled, then drain.
        pulse_reset();
        for (int i = 0; i < 5; i++) commit(32'h1000 + i, 32'h8000_1000 + 4 * i, 0);
        for (int i = 0; i < 4; i++) idle(1);
        idle(1);

        // Full queue with simultaneous push and pop.
        pulse_reset();
        for (int i = 0; i < 4; i++) commit(32'h2000 + i, 32'h8000_2000 + 4 * i, 0);
        commit(32'h2004, 32'h8000_2010, 1);
        for (int i = 0; i < 5; i++) idle(1);

        // Reset with queued records and a read+write pending.
        for (int i = 0; i < 3; i++) commit(32'h3000 + i, 32'h8000_3000 + 4 * i, 0);
        cyc(0, 0, 0, 1, 32'h300, 32'hAA, 6'd8, 1, 32'h304, 32'hBB, 6'd16, 0);
        pulse_reset();
        commit(32'h4000, 32'h8000_4000, 1);
        idle(1);
        idle(1);

        // Randomised traffic.
        pulse_reset();
        for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom, $urandom,
                $urandom_range(0, 3) == 0, $urandom, $urandom, 6'd32,
                $urandom_range(0, 3) == 0, $urandom, $urandom, 6'd16,
                $urandom_range(0, 4) < 3);
        end
        for (int i = 0; i < 6; i++) idle(1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/commit_record_fifo.md
# commit_record_fifo

Formal-harness stage between the core's commit/trace wrapper and the ISA reference checker. It fuses each instruction commit with the memory read and write events that belong to it into one commit record, even when those events arrive in earlier cycles. It queues the records and hands them to the checker over a valid/ready handshake. This decouples checker back-pressure from core commit timing and flags tracing protocol violations as sticky errors.

## Interface
Parameters:
- DEPTH, 4: record FIFO entries; power of two, ≥2.
- XLEN, 32: data/address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instCommit_valid  in  1  instruction retires this cycle.
- instCommit_inst  in  32  retired instruction word.
- instCommit_pc  in  XLEN  retired PC.
- mem_read_valid  in  1  load event.
- mem_read_addr / mem_read_data  in  XLEN  load address / data.
- mem_read_memWidth  in  6  load width in bits (8/16/32).
- mem_write_valid  in  1  store event.
- mem_write_addr / mem_write_data  in  XLEN  store address / data.
- mem_write_memWidth  in  6  store width in bits.
- out_valid  out  1  head record valid.
- out_ready  in  1  checker accepts head.
- out_inst, out_pc  out  32/XLEN  head record commit fields.
- out_rd_valid, out_rd_addr, out_rd_data, out_rd_width  out  1/XLEN/XLEN/6  head load fields.
- out_wr_valid, out_wr_addr, out_wr_data, out_wr_width  out  1/XLEN/XLEN/6  head store fields.
- overflow  out  1  sticky: a record was dropped on a full FIFO.
- seq_error  out  1  sticky: a second event of the same kind arrived before its commit.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Pending slot FSM with states IDLE, PEND_R, PEND_W, PEND_RW. It holds mem events that arrive without a commit in the same cycle.
- Mem event without commit:
  - Latch the event into the slot.
  - Transitions: IDLE→PEND_R or PEND_W; PEND_R + write→PEND_RW; PEND_W + read→PEND_RW.
  - Read while in PEND_R or PEND_RW, or write while in PEND_W or PEND_RW: the newer event overwrites the older one and seq_error is set.
- Commit:
  - Form the record from the commit fields plus the pending slot contents.
  - A same-cycle mem event takes priority over a pending event of the same kind; seq_error is set in that case.
  - Push the record and return the FSM to IDLE.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(DEPTH)+1.
  - Full when pointer MSBs differ and the LSBs are equal.
  - out_* always reflect the head entry; all zero when empty.
- Pop: out_valid && out_ready.
- Push when full:
  - With a same-cycle pop: the push succeeds and count is unchanged.
  - Without a pop: the record is dropped and overflow is set. The pending slot still clears.
- Simultaneous push and pop when empty: the push lands and the pop does not occur, since out_valid was 0.
- overflow and seq_error are cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert is external):
  - out_valid=0, all out_*=0, count=0, overflow=0, seq_error=0.
  - FSM=IDLE, pointers=0.
- Latency: commit in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty. No combinational path from inputs to outputs.
- out_* are stable while out_valid && !out_ready.
- Pop in cycle N advances the head in N+1.
- Throughput: one record per cycle.
- Reset mid-operation discards pending and queued records.

## Structure
- Package commit_trace_pkg holds:
  - the typedef commit_rec_t (inst, pc, and rd/wr valid/addr/data/width);
  - the typedef pend_state_e;
  - the width constants MEMW_W=6 and INST_W=32.
- One sub-module, record_fifo: a generic DEPTH×commit_rec_t FIFO with push, pop, full, empty and count. The top level holds the pending FSM and the error flags.

## Test plan
- Load fused: mem_read (addr 0x80000010, data 0xDEADBEEF, width 32) in cycle 2, commit (pc 0x80000004, inst 0x0002A303) in cycle 4 → in cycle 5 out_valid=1, out_rd_valid=1, out_rd_data=0xDEADBEEF, out_wr_valid=0.
- Same-cycle store and commit (addr 0x100, data 0x55, width 8) → next-cycle record has out_wr_valid=1, out_wr_width=8, and seq_error stays 0.
- Two mem_reads (data 0x1 then 0x2) before one commit → record carries data 0x2 and seq_error=1.
- out_ready=0 with DEPTH=4 and 5 commits → count=4, overflow=1, head is the first record. Then out_ready=1 → 4 pops in order, count=0.
- Full FIFO with a same-cycle push and pop → count stays 4 and overflow stays 0.
- reset_n pulled low with 3 queued records and PEND_RW → out_valid=0, count=0, flags clear immediately. The next commit yields a record with no mem fields.
